// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the serial-bus arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bus_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so that other blocks can decode them
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_S_GRANT = 2'd1,
        ST_M_GRANT = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Slave IDs are 3 bits on the wire, so at most 8 slaves
    localparam int SLAVE_ID_WIDTH = 3;
    localparam int MAX_SLAVES     = 1 << SLAVE_ID_WIDTH;

    // Index of the lowest set bit (fixed priority: slave 0 is highest)
    function automatic logic [SLAVE_ID_WIDTH-1:0] lowest_set_idx(input logic [MAX_SLAVES-1:0] v);
        logic [SLAVE_ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SLAVE_ID_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first requester found searching upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is present.
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             vld
);

    logic [PTR_W-1:0] cand;

    // Walk the N positions starting at ptr, keep the first requester
    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N);
            if (!vld && req[cand]) begin
                vld         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared serial bus: slave responses first, then round-robin masters.
// Latency: request sampled in IDLE is granted on that edge; >=1 RELEASE cycle between tenures.
// Backpressure: a tenure ends on done, on request withdrawal, or when the tenure timer expires.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MASTER_COUNT   = 3,
    parameter int SLAVE_COUNT    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [MASTER_COUNT-1:0] m_req,
    input  logic [MASTER_COUNT-1:0] m_done,
    input  logic [SLAVE_COUNT-1:0]  s_req,
    input  logic [SLAVE_COUNT-1:0]  s_done,
    output logic [MASTER_COUNT-1:0] m_grant,
    output logic [SLAVE_COUNT-1:0]  s_cmd,
    output logic                    bus_util,
    output logic                    bus_busy,
    output logic                    timeout
);

    localparam int PTR_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MASTER_COUNT-1:0] m_grant_q, m_grant_d;
    logic [SLAVE_COUNT-1:0]  s_cmd_q, s_cmd_d;
    logic                    bus_util_q, bus_util_d;
    logic                    bus_busy_q, bus_busy_d;
    logic                    timeout_q, timeout_d;

    logic [MASTER_COUNT-1:0] pick_grant;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_vld;

    logic [MAX_SLAVES-1:0]     s_req_ext;
    logic [SLAVE_ID_WIDTH-1:0] s_idx;
    logic [SLAVE_COUNT-1:0]    s_sel;

    logic m_end, s_end, expired;

    rr_picker #(
        .N     (MASTER_COUNT),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req   (m_req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    // Slave fixed priority: lowest index wins
    assign s_req_ext = MAX_SLAVES'(s_req);
    assign s_idx     = lowest_set_idx(s_req_ext);
    assign s_sel     = SLAVE_COUNT'(1) << s_idx;

    // Tenure end conditions only look at the current owner, so stray done pulses are ignored
    assign m_end   = (|(m_done & m_grant_q)) || !(|(m_req & m_grant_q));
    assign s_end   = (|(s_done & s_cmd_q)) || !(|(s_req & s_cmd_q));
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, grant, pointer and tenure-timer computation
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        m_grant_d  = m_grant_q;
        s_cmd_d    = s_cmd_q;
        bus_util_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|s_req) begin
                    state_d = ST_S_GRANT;
                    s_cmd_d = s_sel;
                    cnt_d   = '0;
                end else if (pick_vld) begin
                    state_d   = ST_M_GRANT;
                    m_grant_d = pick_grant;
                    rr_ptr_d  = (pick_idx == PTR_W'(MASTER_COUNT - 1)) ? '0 : pick_idx + PTR_W'(1);
                    cnt_d     = '0;
                end
            end
            ST_S_GRANT: begin
                if (s_end || expired) begin
                    state_d    = ST_RELEASE;
                    s_cmd_d    = '0;
                    bus_util_d = 1'b1;
                    timeout_d  = !s_end;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_M_GRANT: begin
                if (m_end || expired) begin
                    state_d    = ST_RELEASE;
                    m_grant_d  = '0;
                    bus_util_d = 1'b1;
                    timeout_d  = !m_end;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // RELEASE lasts exactly one cycle; requests are looked at again from IDLE
                state_d = ST_IDLE;
            end
        endcase

        bus_busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset drops everything without a release pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            m_grant_q  <= '0;
            s_cmd_q    <= '0;
            bus_util_q <= 1'b0;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            m_grant_q  <= m_grant_d;
            s_cmd_q    <= s_cmd_d;
            bus_util_q <= bus_util_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign m_grant  = m_grant_q;
    assign s_cmd    = s_cmd_q;
    assign bus_util = bus_util_q;
    assign bus_busy = bus_busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a tenure-level reference model.
module tb_bus_arbiter;

    localparam int MC = 3;
    localparam int SC = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [MC-1:0] m_req = '0;
    logic [MC-1:0] m_done = '0;
    logic [SC-1:0] s_req = '0;
    logic [SC-1:0] s_done = '0;
    logic [MC-1:0] m_grant;
    logic [SC-1:0] s_cmd;
    logic          bus_util;
    logic          bus_busy;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .MASTER_COUNT   (MC),
        .SLAVE_COUNT    (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .m_req    (m_req),
        .m_done   (m_done),
        .s_req    (s_req),
        .s_done   (s_done),
        .m_grant  (m_grant),
        .s_cmd    (s_cmd),
        .bus_util (bus_util),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    typedef struct {
        logic          rstn;
        logic [MC-1:0] mreq;
        logic [MC-1:0] mdone;
        logic [SC-1:0] sreq;
        logic [SC-1:0] sdone;
        logic [MC-1:0] mg;
        logic [SC-1:0] sc;
        logic          util;
        logic          busy;
        logic          tmo;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who owns the bus, how long it has held it, whether the
    // mandatory gap cycle is pending, and which master gets first look next time.
    int owner_kind;   // 0 none, 1 slave, 2 master
    int owner_idx;
    int age;
    int gap;
    int next_m;
    logic [MC-1:0] exp_mg;
    logic [SC-1:0] exp_sc;
    logic          exp_util, exp_busy, exp_tmo;

    task automatic add(input logic r, input logic [2:0] mq, input logic [2:0] md,
                       input logic [2:0] sq, input logic [2:0] sd, input logic [2:0] mg,
                       input logic [2:0] sc, input logic u, input logic b, input logic t);
        vec_t v;
        v.rstn = r; v.mreq = mq; v.mdone = md; v.sreq = sq; v.sdone = sd;
        v.mg = mg; v.sc = sc; v.util = u; v.busy = b; v.tmo = t;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [MC-1:0] mg, input logic [SC-1:0] sc,
                              input logic u, input logic b, input logic t);
        check({tag, ".m_grant"},  8'(m_grant),  8'(mg));
        check({tag, ".s_cmd"},    8'(s_cmd),    8'(sc));
        check({tag, ".bus_util"}, 8'(bus_util), 8'(u));
        check({tag, ".bus_busy"}, 8'(bus_busy), 8'(b));
        check({tag, ".timeout"},  8'(timeout),  8'(t));
    endtask

    // Inputs are applied between edges; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        logic ended;
        exp_util = 1'b0;
        exp_tmo  = 1'b0;
        if (!rstn) begin
            owner_kind = 0; owner_idx = 0; age = 0; gap = 0; next_m = 0;
        end else if (gap != 0) begin
            gap = 0;
        end else if (owner_kind == 0) begin
            if (s_req != 0) begin
                for (int j = SC - 1; j >= 0; j--) if (s_req[j]) owner_idx = j;
                owner_kind = 1;
                age = 0;
            end else if (m_req != 0) begin
                for (int n = MC - 1; n >= 0; n--) begin
                    if (m_req[(next_m + n) % MC]) owner_idx = (next_m + n) % MC;
                end
                owner_kind = 2;
                next_m = (owner_idx + 1) % MC;
                age = 0;
            end
        end else begin
            if (owner_kind == 1) ended = s_done[owner_idx] || !s_req[owner_idx];
            else                 ended = m_done[owner_idx] || !m_req[owner_idx];
            if (ended || age == TO - 1) begin
                exp_util   = 1'b1;
                exp_tmo    = !ended;
                owner_kind = 0;
                gap        = 1;
            end else begin
                age++;
            end
        end
        exp_mg   = (owner_kind == 2) ? MC'(1 << owner_idx) : '0;
        exp_sc   = (owner_kind == 1) ? SC'(1 << owner_idx) : '0;
        exp_busy = (owner_kind != 0) || (gap != 0);
    endtask

    initial begin
        logic [MC-1:0] rr_exp [4];
        int waited;
        int n;

        // rstn mreq  mdone  sreq   sdone  | m_grant s_cmd util busy tmo
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0); // reset state
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 1, 0); // single grant
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 1, 0);
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 1, 0);
        add(1, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0); // done -> release
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0); // idle
        add(1, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 0, 1, 0); // slave outranks master
        add(1, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 0, 1, 0);
        add(1, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 1, 1, 0); // s_done -> release
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0); // idle
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 0, 1, 0); // master 0 granted
        add(1, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 0, 1, 0); // stray done ignored
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0); // withdrawal ends tenure
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 1, 0);
        add(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0); // reset mid-tenure
        add(1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 0, 1, 0); // grant after reset
        add(1, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        add(1, 3'b000, 3'b000, 3'b011, 3'b010, 3'b000, 3'b001, 0, 1, 0); // lowest slave first
        add(1, 3'b000, 3'b010, 3'b011, 3'b010, 3'b000, 3'b001, 0, 1, 0); // stray dones ignored
        add(1, 3'b000, 3'b000, 3'b011, 3'b001, 3'b000, 3'b000, 1, 1, 0);
        add(1, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        add(1, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010, 0, 1, 0); // next slave
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0); // slave withdrawal
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            rstn = tbl[i].rstn; m_req = tbl[i].mreq; m_done = tbl[i].mdone;
            s_req = tbl[i].sreq; s_done = tbl[i].sdone;
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].mg, tbl[i].sc, tbl[i].util, tbl[i].busy, tbl[i].tmo);
        end

        // Round-robin with all masters requesting, 3-cycle tenures, pointer wraps 2 -> 0
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        rstn = 1'b0; m_req = '0; m_done = '0; s_req = '0; s_done = '0;
        step();
        rstn = 1'b1; m_req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (m_grant == '0 && waited < 6);
            check($sformatf("rr_grant%0d", t), 8'(m_grant), 8'(rr_exp[t]));
            check($sformatf("rr_latency%0d", t), 8'(waited), (t == 0) ? 8'd1 : 8'd2);
            step();
            check($sformatf("rr_hold%0d", t), 8'(m_grant), 8'(rr_exp[t]));
            m_done = m_grant;
            step();
            m_done = '0;
            check($sformatf("rr_release%0d", t), {6'd0, bus_util, |m_grant}, 8'b10);
        end
        m_req = '0;
        step();

        // Timer revoke: never done, grant held exactly TO cycles, timeout with bus_util
        rstn = 1'b0; step();
        rstn = 1'b1; m_req = 3'b001;
        step();
        check("to_grant", 8'(m_grant), 8'b001);
        n = 0;
        do begin
            step();
            n++;
        end while (m_grant != '0 && n < 20);
        check("to_len", 8'(n), 8'(TO));
        check("to_pulse", 8'(timeout), 8'd1);
        check("to_util", 8'(bus_util), 8'd1);
        m_req = '0;
        step();
        check("to_one_cycle", 8'(timeout), 8'd0);

        // Done on the expiry cycle wins over the timer
        rstn = 1'b0; step();
        rstn = 1'b1; m_req = 3'b001;
        step();
        repeat (TO - 1) step();
        check("dt_hold", 8'(m_grant), 8'b001);
        m_done = 3'b001;
        step();
        m_done = '0; m_req = '0;
        check_outs("dt_end", 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        step();

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn = (cyc == 0) ? 1'b0 : ($urandom_range(63) != 0);
            for (int i = 0; i < MC; i++) begin
                if ($urandom_range(7) == 0) m_req[i] = ~m_req[i];
                m_done[i] = ($urandom_range(9) == 0);
            end
            for (int j = 0; j < SC; j++) begin
                if ($urandom_range(7) == 0) s_req[j] = ~s_req[j];
                s_done[j] = ($urandom_range(9) == 0);
            end
            model_step();
            step();
            check_outs($sformatf("rand%0d", cyc), exp_mg, exp_sc, exp_util, exp_busy, exp_tmo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
